req_join: RTL and testbench

- Clocked, parametrised successor to the asynchronous all-requests-risen detector used for completion joins in the flow-control layer.
- Latches rising edges on up to reqNumber request lines and qualifies them with a per-channel enable mask.
- Fires a fin pulse of programmable width when all enabled channels, or a run-time K of them, have risen.
- Adds input synchronisation, timeout abort, duplicate-edge detection and status outputs; sits between worker modules and the next pipeline stage's start request.

---
 rtl/req_join.sv | 179 +++++++++++++++++
 tb/tb_req_join.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/req_join.sv
// req_join -- clocked completion join.
// Latches rising edges on reqNumber request lines, qualifies them with a
// per-channel enable mask, and emits a fin pulse of FIN_WIDTH cycles once all
// enabled channels (threshold == 0) or `threshold` of them have completed.
// An optional cycle timeout aborts a stalled collection round.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   reqs       request lines; a rising edge marks a channel done
//   enMask     1 = channel participates (sampled every cycle)
//   threshold  completions required; 0 = all enabled channels
//   clear      synchronous abort/flush
//   fin        registered completion pulse (FIN_WIDTH cycles)
//   timeout    one-cycle abort pulse
//   overrun    one-cycle pulse: repeat edge on an already-saved channel
//   busy       state != IDLE
//   pending    enMask & ~reqsSave
//   doneCount  popcount(reqsSave & enMask)
module req_join #(
  parameter int unsigned reqNumber = 2,
  parameter int unsigned SYNC      = 1,
  parameter int unsigned FIN_WIDTH = 1,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [reqNumber-1:0]               reqs,
  input  logic [reqNumber-1:0]               enMask,
  input  logic [$clog2(reqNumber+1)-1:0]     threshold,
  input  logic                               clear,
  output logic                               fin,
  output logic                               timeout,
  output logic                               overrun,
  output logic                               busy,
  output logic [reqNumber-1:0]               pending,
  output logic [$clog2(reqNumber+1)-1:0]     doneCount
);

  localparam int unsigned N    = reqNumber;
  localparam int unsigned CW   = $clog2(reqNumber + 1);
  localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [7:0]  FLAST = 8'(FIN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FIRE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   s;
  logic [N-1:0]   prev_q;
  logic [N-1:0]   edge_s;
  logic [N-1:0]   save_q, save_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]     fin_cnt_q, fin_cnt_d;
  logic           fin_q, fin_d;
  logic           tmo_q, tmo_d;
  logic           ovr_q, ovr_d;
  logic [CW-1:0]  done_cnt;
  logic [CW-1:0]  en_cnt;
  logic [CW-1:0]  eff_thr;
  logic           complete;
  logic           tmo_hit;

  generate
    if (SYNC != 0) begin : g_sync
      logic [N-1:0] sync1_q, sync2_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= reqs;
          sync2_q <= sync1_q;
        end
      end
      assign s = sync2_q;
    end else begin : g_nosync
      assign s = reqs;
    end
  endgenerate

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  assign edge_s   = s & ~prev_q;
  assign done_cnt = popcnt(save_q & enMask);
  assign en_cnt   = popcnt(enMask);
  assign eff_thr  = (threshold == '0) ? en_cnt : threshold;
  assign complete = (done_cnt >= eff_thr) && (enMask != '0);
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt_q >= TW'(TLIM));

  always_comb begin
    state_d   = state_q;
    save_d    = save_q;
    tmo_cnt_d = tmo_cnt_q;
    fin_cnt_d = fin_cnt_q;
    tmo_d     = 1'b0;
    ovr_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        save_d = save_q | edge_s;
        if (save_q != '0) begin
          state_d   = COLLECT;
          tmo_cnt_d = '0;
        end
      end
      COLLECT: begin
        ovr_d = |(edge_s & save_q);
        // Completion takes priority over a simultaneous timeout. Edges seen
        // on the firing edge seed the next round's save vector.
        if (complete) begin
          state_d   = FIRE;
          save_d    = edge_s;
          fin_cnt_d = '0;
        end else if (tmo_hit) begin
          state_d = IDLE;
          save_d  = '0;
          tmo_d   = 1'b1;
        end else begin
          save_d = save_q | edge_s;
          if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      FIRE: begin
        save_d = save_q | edge_s;
        if (fin_cnt_q == FLAST) begin
          state_d   = (save_q != '0) ? COLLECT : IDLE;
          tmo_cnt_d = '0;
        end else begin
          fin_cnt_d = fin_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d   = IDLE;
      save_d    = '0;
      tmo_cnt_d = '0;
      fin_cnt_d = '0;
      tmo_d     = 1'b0;
      ovr_d     = 1'b0;
    end
    fin_d = (state_d == FIRE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      save_q    <= '0;
      tmo_cnt_q <= '0;
      fin_cnt_q <= '0;
      fin_q     <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= s;
      save_q    <= save_d;
      tmo_cnt_q <= tmo_cnt_d;
      fin_cnt_q <= fin_cnt_d;
      fin_q     <= fin_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
    end
  end

  assign fin       = fin_q;
  assign timeout   = tmo_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
  assign pending   = enMask & ~save_q;
  assign doneCount = done_cnt;

endmodule

// File: tb/tb_req_join.sv
// Bench for req_join: three instances (SYNC=0/FIN_WIDTH=1/TIMEOUT=10,
// SYNC=0/FIN_WIDTH=3/no timeout, SYNC=1/FIN_WIDTH=1/no timeout).
// Expected output values are queued with the cycle at which they must appear
// and compared by a monitor on the falling clock edge.
module tb_req_join;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rstn_v [3];
  logic [3:0] reqs_v [3];
  logic [3:0] en_v   [3];
  logic [2:0] thr_v  [3];
  logic       clr_v  [3];
  logic       fin_v  [3];
  logic       tmo_v  [3];
  logic       ovr_v  [3];
  logic       busy_v [3];
  logic [3:0] pend_v [3];
  logic [2:0] done_v [3];

  req_join #(.reqNumber(4), .SYNC(0), .FIN_WIDTH(1), .TIMEOUT(10)) u_dut0 (
    .clk(clk), .rstn(rstn_v[0]), .reqs(reqs_v[0]), .enMask(en_v[0]),
    .threshold(thr_v[0]), .clear(clr_v[0]), .fin(fin_v[0]), .timeout(tmo_v[0]),
    .overrun(ovr_v[0]), .busy(busy_v[0]), .pending(pend_v[0]), .doneCount(done_v[0]));

  req_join #(.reqNumber(4), .SYNC(0), .FIN_WIDTH(3), .TIMEOUT(0)) u_dut1 (
    .clk(clk), .rstn(rstn_v[1]), .reqs(reqs_v[1]), .enMask(en_v[1]),
    .threshold(thr_v[1]), .clear(clr_v[1]), .fin(fin_v[1]), .timeout(tmo_v[1]),
    .overrun(ovr_v[1]), .busy(busy_v[1]), .pending(pend_v[1]), .doneCount(done_v[1]));

  req_join #(.reqNumber(4), .SYNC(1), .FIN_WIDTH(1), .TIMEOUT(0)) u_dut2 (
    .clk(clk), .rstn(rstn_v[2]), .reqs(reqs_v[2]), .enMask(en_v[2]),
    .threshold(thr_v[2]), .clear(clr_v[2]), .fin(fin_v[2]), .timeout(tmo_v[2]),
    .overrun(ovr_v[2]), .busy(busy_v[2]), .pending(pend_v[2]), .doneCount(done_v[2]));

  typedef enum {S_FIN, S_TMO, S_OVR, S_BUSY, S_PEND, S_DONE} sig_e;
  typedef struct {
    int    dut;
    int    at;
    sig_e  sig;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic exp_at(input int d, input int off, input sig_e s, input int v, input string tag);
    exp_t e;
    e.dut = d;
    e.at  = cyc + off;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] obs(input int d, input sig_e s);
    case (s)
      S_FIN:   return {31'b0, fin_v[d]};
      S_TMO:   return {31'b0, tmo_v[d]};
      S_OVR:   return {31'b0, ovr_v[d]};
      S_BUSY:  return {31'b0, busy_v[d]};
      S_PEND:  return {28'b0, pend_v[d]};
      default: return {29'b0, done_v[d]};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        chk($sformatf("%s d%0d c%0d", sb[i].tag, sb[i].dut, sb[i].at),
            obs(sb[i].dut, sb[i].sig), 32'(sb[i].val));
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstn_v[d] = 1'b0;
      reqs_v[d] = 4'b0000;
      en_v[d]   = 4'b1111;
      thr_v[d]  = 3'd0;
      clr_v[d]  = 1'b0;
    end
    tick(3);

    // Reset state, observed while rstn is still low.
    for (int d = 0; d < 3; d++) begin
      exp_at(d, 0, S_FIN,  0,       "rst_fin");
      exp_at(d, 0, S_BUSY, 0,       "rst_busy");
      exp_at(d, 0, S_DONE, 0,       "rst_done");
      exp_at(d, 0, S_PEND, 4'b1111, "rst_pend");
      exp_at(d, 0, S_TMO,  0,       "rst_tmo");
      exp_at(d, 0, S_OVR,  0,       "rst_ovr");
    end
    tick(1);
    for (int d = 0; d < 3; d++) rstn_v[d] = 1'b1;
    tick(2);

    // All four channels rise one per cycle; threshold 0 = all enabled.
    exp_at(0, 1, S_DONE, 1, "t1_done1");
    exp_at(0, 2, S_DONE, 2, "t1_done2");
    exp_at(0, 3, S_DONE, 3, "t1_done3");
    exp_at(0, 4, S_DONE, 4, "t1_done4");
    exp_at(0, 5, S_DONE, 0, "t1_done0");
    exp_at(0, 1, S_BUSY, 0, "t1_busy_idle");
    exp_at(0, 4, S_FIN,  0, "t1_fin_early");
    exp_at(0, 5, S_FIN,  1, "t1_fin");
    exp_at(0, 6, S_FIN,  0, "t1_fin_end");
    exp_at(0, 5, S_BUSY, 1, "t1_busy_fire");
    exp_at(0, 6, S_BUSY, 0, "t1_busy_fall");
    reqs_v[0] = 4'b0001; tick(1);
    reqs_v[0] = 4'b0011; tick(1);
    reqs_v[0] = 4'b0111; tick(1);
    reqs_v[0] = 4'b1111; tick(4);
    reqs_v[0] = 4'b0000; tick(2);

    // Masked channel 1 is saved but not counted.
    en_v[0] = 4'b0101;
    exp_at(0, 1, S_PEND, 4'b0101, "t2_pend_a");
    exp_at(0, 1, S_DONE, 0,       "t2_done_masked");
    exp_at(0, 3, S_PEND, 4'b0100, "t2_pend_b");
    exp_at(0, 4, S_DONE, 1,       "t2_done1");
    exp_at(0, 5, S_DONE, 2,       "t2_done2");
    exp_at(0, 5, S_FIN,  0,       "t2_fin_early");
    exp_at(0, 6, S_FIN,  1,       "t2_fin");
    exp_at(0, 7, S_BUSY, 0,       "t2_busy_fall");
    reqs_v[0] = 4'b0010; tick(2);
    reqs_v[0] = 4'b0011; tick(2);
    reqs_v[0] = 4'b0111; tick(5);
    reqs_v[0] = 4'b0000;
    en_v[0]   = 4'b1111;
    tick(2);

    // Timeout: COLLECT entered 2 edges after the stimulus, abort 10 later.
    exp_at(0, 11, S_DONE, 1, "t4_done_pre");
    exp_at(0, 11, S_BUSY, 1, "t4_busy_pre");
    exp_at(0, 11, S_TMO,  0, "t4_tmo_early");
    exp_at(0, 12, S_TMO,  1, "t4_tmo");
    exp_at(0, 13, S_TMO,  0, "t4_tmo_end");
    exp_at(0, 12, S_FIN,  0, "t4_fin");
    exp_at(0, 12, S_DONE, 0, "t4_done_post");
    exp_at(0, 12, S_BUSY, 0, "t4_busy_post");
    reqs_v[0] = 4'b0001; tick(14);
    reqs_v[0] = 4'b0000; tick(2);

    // Overrun on a repeat edge, then clear with three saved channels.
    exp_at(0, 3, S_OVR,  0, "t5_ovr_early");
    exp_at(0, 4, S_OVR,  1, "t5_ovr");
    exp_at(0, 5, S_OVR,  0, "t5_ovr_end");
    exp_at(0, 4, S_DONE, 1, "t5_done_dup");
    exp_at(0, 6, S_DONE, 3, "t5_done3");
    exp_at(0, 6, S_BUSY, 1, "t5_busy");
    exp_at(0, 7, S_DONE, 0, "t6_clr_done");
    exp_at(0, 7, S_BUSY, 0, "t6_clr_busy");
    exp_at(0, 8, S_DONE, 0, "t6_clr_discard");
    exp_at(0, 8, S_BUSY, 0, "t6_clr_idle");
    reqs_v[0] = 4'b0100; tick(2);
    reqs_v[0] = 4'b0000; tick(1);
    reqs_v[0] = 4'b0100; tick(2);
    reqs_v[0] = 4'b0111; tick(1);
    reqs_v[0] = 4'b1111;
    clr_v[0]  = 1'b1;    tick(1);
    clr_v[0]  = 1'b0;    tick(3);
    reqs_v[0] = 4'b0000; tick(2);

    // threshold=2, FIN_WIDTH=3; an edge during FIRE seeds the next round.
    thr_v[1] = 3'd2;
    exp_at(1, 2, S_FIN,  0, "t3_fin_early");
    exp_at(1, 3, S_FIN,  1, "t3_fin1");
    exp_at(1, 4, S_FIN,  1, "t3_fin2");
    exp_at(1, 5, S_FIN,  1, "t3_fin3");
    exp_at(1, 6, S_FIN,  0, "t3_fin_end");
    exp_at(1, 3, S_DONE, 0, "t3_done_fire");
    exp_at(1, 6, S_DONE, 1, "t3_done_next");
    exp_at(1, 6, S_BUSY, 1, "t3_busy_collect");
    reqs_v[1] = 4'b1000; tick(1);
    reqs_v[1] = 4'b1010; tick(3);
    reqs_v[1] = 4'b1011; tick(3);
    clr_v[1]  = 1'b1;    tick(1);
    clr_v[1]  = 1'b0;
    reqs_v[1] = 4'b0000;
    exp_at(1, 0, S_BUSY, 0, "t3_clr_busy");
    exp_at(1, 0, S_DONE, 0, "t3_clr_done");
    tick(2);

    // threshold=1: IDLE->COLLECT->FIRE back to back; async reset mid-FIRE.
    thr_v[1] = 3'd1;
    exp_at(1, 2, S_BUSY, 1, "t7_busy");
    exp_at(1, 2, S_FIN,  0, "t7_fin_early");
    exp_at(1, 3, S_FIN,  1, "t7_fin");
    exp_at(1, 4, S_FIN,  0, "t7_async_fin");
    exp_at(1, 4, S_BUSY, 0, "t7_async_busy");
    reqs_v[1] = 4'b0001; tick(4);
    rstn_v[1] = 1'b0;    tick(1);
    rstn_v[1] = 1'b1;
    reqs_v[1] = 4'b0000; tick(2);

    // SYNC=1: save lands two edges later than SYNC=0.
    thr_v[2] = 3'd1;
    exp_at(2, 1, S_DONE, 0, "t8_done_s1");
    exp_at(2, 2, S_DONE, 0, "t8_done_s2");
    exp_at(2, 3, S_DONE, 1, "t8_done_saved");
    exp_at(2, 4, S_FIN,  0, "t8_fin_early");
    exp_at(2, 5, S_FIN,  1, "t8_fin");
    exp_at(2, 6, S_FIN,  0, "t8_fin_end");
    reqs_v[2] = 4'b0001; tick(8);
    reqs_v[2] = 4'b0000; tick(4);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
